seg_disp_arbiter: RTL and testbench
===================================

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

Interface
REQ-001 Parameter HOLD_CYC, default 50_000_000: minimum dwell of one granted source on the display, in sys_clk cycles (1 s at 50 MHz).
REQ-002 Parameter GAP_CYC, default 50_000: blanking cycles between two different sources (1 ms).
REQ-003 Parameter BLINK_CYC, default 12_500_000: half-period of blink toggling.
REQ-004 sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 sys_rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  3  per-source display request, level; bit 0 is the urgent (alarm) source.
REQ-007 data0, data1, data2  in  16 each  source display values.
REQ-008 point0, point1, point2  in  6 each  source decimal-point masks.
REQ-009 sign  in  3  per-source negative-sign flag.
REQ-010 blink  in  3  per-source blink enable.
REQ-011 disp_data  out  16  value to display driver data input.
REQ-012 disp_point  out  6  to display driver point input.
REQ-013 disp_sign  out  1  to display driver sign input.
REQ-014 disp_seg_en  out  1  to display driver seg_en; 0 blanks all digits.
REQ-015 grant  out  3  one-hot current owner; 0 when none.

Function
REQ-016 States: IDLE, SHOW, GAP; encoded in shared package.
REQ-017 IDLE: grant=0, disp_seg_en=0; if any req bit is 1, register grant to the picked source and enter SHOW next cycle, loading the dwell counter with HOLD_CYC-1.
REQ-018 Pick rule: req[0] wins if set; otherwise round-robin over bits 1..2 starting after the last granted index (pointer updates on every grant).
REQ-019 SHOW: every cycle, disp_data/disp_point/disp_sign register the granted source's inputs (1-cycle latency from grant to first valid value); disp_seg_en=1 unless blinking (REQ-021).
REQ-020 SHOW dwell counter decrements to 0 and saturates.
REQ-021 If granted source's blink=1, disp_seg_en toggles every BLINK_CYC cycles, starting at 1 on SHOW entry; blink=0 forces 1 within one cycle.
REQ-022 Leave SHOW to GAP when: granted req bit drops (immediately, regardless of counter); or counter=0 and another req bit is set; or req[0]=1 while source 1 or 2 is granted (preemption, ignores counter).
REQ-023 Counter=0 with no other request: remain in SHOW indefinitely.
REQ-024 Simultaneous owner-drop and preemption: single transition to GAP; next pick is source 0.
REQ-025 GAP: grant=0, disp_seg_en=0, disp_data/point/sign hold last values, for exactly GAP_CYC cycles; then pick as in REQ-017 (to SHOW) or enter IDLE if req=0.
REQ-026 Requests are not latched; a req pulse shorter than one sample in IDLE/GAP-end is lost.
REQ-027 grant is always one-hot or zero.

Reset
REQ-028 On sys_rst=1 at a clock edge: state=IDLE, grant=0, disp_data=0, disp_point=0, disp_sign=0, disp_seg_en=0, counters=0, round-robin pointer=2 (so source 1 is preferred first).
REQ-029 Reset asserted mid-SHOW or mid-GAP takes effect on the same edge with no blanking/gap sequence.

Structure
REQ-030 Shared package seg_pkg holds NUM_SRC=3, the state enum, and source index constants.
REQ-031 One sub-module seg_rr_pick: combinational picker (req, pointer -> one-hot grant, valid); all state, counters and output registers stay in seg_disp_arbiter.
REQ-032 Outputs connect directly to the display driver's data/point/sign/seg_en; its bcd_data is driven outside this block.

Verification (bench params HOLD_CYC=8, GAP_CYC=2, BLINK_CYC=4)
REQ-033 Reset: sys_rst=1 with req=3'b111 -> all outputs 0, grant=0; release -> grant=3'b001 one cycle later.
REQ-034 Round-robin: req=3'b110 constant, data1=16'h0012, data2=16'h0034 -> grant 010 for 8 cycles, 2 blank cycles, grant 100 for 8, 2 blank, grant 010 again.
REQ-035 Preemption: grant=010 at dwell cycle 3, req[0] rises -> next cycle GAP (seg_en=0, grant=0) for 2 cycles, then grant=001.
REQ-036 Sole requester: req=3'b010 only -> grant 010 held beyond 8 cycles indefinitely; drop req[1] -> GAP 2 cycles then IDLE.
REQ-037 Blink: grant=100, blink[2]=1 -> disp_seg_en pattern 1,1,1,1,0,0,0,0 repeating; clear blink[2] -> 1 next cycle.
REQ-038 Mid-GAP reset: assert sys_rst during GAP cycle 1 -> IDLE next edge, all outputs 0, pointer=2.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the display arbiter: source count, FSM states and
// fixed source indices.
package seg_pkg;

  localparam int NUM_SRC   = 3;
  localparam int SRC_ALARM = 0;
  localparam int SRC_ONE   = 1;
  localparam int SRC_TWO   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Converts a one-hot grant into the index the round-robin pointer stores.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_disp_arbiter_rr_pick.sv
// Combinational source picker: the alarm source always wins, otherwise
// sources 1 and 2 alternate starting after the last granted index.
module seg_rr_pick
  import seg_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic               valid_o
);

  always_comb begin
    gnt_o   = '0;
    valid_o = |req_i;
    if (req_i[SRC_ALARM]) begin
      gnt_o[SRC_ALARM] = 1'b1;
    end else if (ptr_i == 2'(SRC_ONE)) begin
      if (req_i[SRC_TWO])      gnt_o[SRC_TWO] = 1'b1;
      else if (req_i[SRC_ONE]) gnt_o[SRC_ONE] = 1'b1;
    end else begin
      if (req_i[SRC_ONE])      gnt_o[SRC_ONE] = 1'b1;
      else if (req_i[SRC_TWO]) gnt_o[SRC_TWO] = 1'b1;
    end
  end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Shares one 7-segment display between three sources: minimum dwell per
// owner, a blanking gap between owners, alarm preemption and optional blink.
module seg_disp_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned HOLD_CYC  = 50_000_000,
  parameter int unsigned GAP_CYC   = 50_000,
  parameter int unsigned BLINK_CYC = 12_500_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_SRC-1:0]  req,
  input  logic [15:0]         data0,
  input  logic [15:0]         data1,
  input  logic [15:0]         data2,
  input  logic [5:0]          point0,
  input  logic [5:0]          point1,
  input  logic [5:0]          point2,
  input  logic [NUM_SRC-1:0]  sign,
  input  logic [NUM_SRC-1:0]  blink,
  output logic [15:0]         disp_data,
  output logic [5:0]          disp_point,
  output logic                disp_sign,
  output logic                disp_seg_en,
  output logic [NUM_SRC-1:0]  grant
);

  localparam int HW = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
  localparam int GW = (GAP_CYC   > 1) ? $clog2(GAP_CYC)   : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [BW-1:0]        blink_q, blink_d;
  logic                 seg_en_q, seg_en_d;
  logic [15:0]          data_q, data_d;
  logic [5:0]           point_q, point_d;
  logic                 sign_q, sign_d;

  logic [NUM_SRC-1:0]   pick_gnt;
  logic                 pick_valid;
  logic                 owner_req, other_req, preempt, leave_show, take_grant;
  logic                 owner_blink;
  logic [15:0]          src_data;
  logic [5:0]           src_point;
  logic                 src_sign;

  seg_rr_pick u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  assign owner_req   = |(req & grant_q);
  assign other_req   = |(req & ~grant_q);
  assign preempt     = req[SRC_ALARM] & ~grant_q[SRC_ALARM];
  assign owner_blink = |(blink & grant_q);
  // Owner drop and preemption ignore the dwell counter.
  assign leave_show  = !owner_req || ((hold_q == '0) && other_req) || preempt;
  assign take_grant  = pick_valid &&
                       ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q == '0)));

  always_comb begin
    src_data  = data0;
    src_point = point0;
    src_sign  = sign[SRC_ALARM];
    if (grant_q[SRC_ONE]) begin
      src_data  = data1;
      src_point = point1;
      src_sign  = sign[SRC_ONE];
    end else if (grant_q[SRC_TWO]) begin
      src_data  = data2;
      src_point = point2;
      src_sign  = sign[SRC_TWO];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= 2'(SRC_TWO);
      hold_q   <= '0;
      gap_q    <= '0;
      blink_q  <= '0;
      seg_en_q <= 1'b0;
      data_q   <= '0;
      point_q  <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      blink_q  <= blink_d;
      seg_en_q <= seg_en_d;
      data_q   <= data_d;
      point_q  <= point_d;
      sign_q   <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_SHOW;
      ST_SHOW: if (leave_show) state_d = ST_GAP;
      ST_GAP:  if (gap_q == '0) state_d = pick_valid ? ST_SHOW : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    blink_d  = blink_q;
    seg_en_d = seg_en_q;
    data_d   = data_q;
    point_d  = point_q;
    sign_d   = sign_q;
    case (state_q)
      ST_SHOW: begin
        data_d  = src_data;
        point_d = src_point;
        sign_d  = src_sign;
        if (leave_show) begin
          grant_d  = '0;
          seg_en_d = 1'b0;
          gap_d    = GW'(GAP_CYC - 1);
        end else begin
          if (hold_q != '0) hold_d = hold_q - HW'(1);
          // Blink phase restarts whenever the owner's blink is off.
          if (owner_blink) begin
            if (blink_q == '0) begin
              seg_en_d = ~seg_en_q;
              blink_d  = BW'(BLINK_CYC - 1);
            end else begin
              blink_d  = blink_q - BW'(1);
            end
          end else begin
            seg_en_d = 1'b1;
            blink_d  = BW'(BLINK_CYC - 1);
          end
        end
      end
      ST_IDLE, ST_GAP: begin
        if (take_grant) begin
          grant_d  = pick_gnt;
          ptr_d    = onehot_to_idx(pick_gnt);
          hold_d   = HW'(HOLD_CYC - 1);
          blink_d  = BW'(BLINK_CYC - 1);
          seg_en_d = 1'b1;
        end else if ((state_q == ST_GAP) && (gap_q != '0)) begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        grant_d  = '0;
        seg_en_d = 1'b0;
      end
    endcase
  end

  assign disp_data   = data_q;
  assign disp_point  = point_q;
  assign disp_sign   = sign_q;
  assign disp_seg_en = seg_en_q;
  assign grant       = grant_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Self-checking bench for seg_disp_arbiter with short dwell/gap/blink periods
// and a cycle-level behavioural model of the arbitration rules.
module tb_seg_disp_arbiter;

  localparam int HOLD  = 8;
  localparam int GAP   = 2;
  localparam int BLINK = 4;

  logic        sys_clk;
  logic        sys_rst;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [5:0]  point0, point1, point2;
  logic [2:0]  sign, blink;
  logic [15:0] disp_data;
  logic [5:0]  disp_point;
  logic        disp_sign, disp_seg_en;
  logic [2:0]  grant;

  int checks = 0;
  int passes = 0;

  // Model: mode 0 idle, 1 showing, 2 blank gap.
  int          m_mode, m_owner, m_last, m_shown, m_gapleft, m_blinkage;
  logic        m_seg, m_sign;
  logic [5:0]  m_point;
  logic [15:0] m_data;

  seg_disp_arbiter #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .BLINK_CYC(BLINK)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req         (req),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .point0      (point0),
    .point1      (point1),
    .point2      (point2),
    .sign        (sign),
    .blink       (blink),
    .disp_data   (disp_data),
    .disp_point  (disp_point),
    .disp_sign   (disp_sign),
    .disp_seg_en (disp_seg_en),
    .grant       (grant)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [26:0] exp_vec();
    logic [2:0] g;
    g = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    return {g, m_seg, m_sign, m_point, m_data};
  endfunction

  function automatic logic [26:0] obs_vec();
    return {grant, disp_seg_en, disp_sign, disp_point, disp_data};
  endfunction

  // Applies the arbitration rules to the inputs sampled at a rising edge.
  task automatic model_step();
    logic [2:0] r;
    logic       leave;
    int         idx;
    r = req;
    if (sys_rst) begin
      m_mode = 0; m_owner = -1; m_last = 2; m_shown = 0; m_gapleft = 0;
      m_blinkage = 0; m_seg = 0; m_sign = 0; m_point = 0; m_data = 0;
      return;
    end
    if (m_mode == 1) begin
      m_data  = (m_owner == 0) ? data0  : (m_owner == 1) ? data1  : data2;
      m_point = (m_owner == 0) ? point0 : (m_owner == 1) ? point1 : point2;
      m_sign  = sign[m_owner];
      leave = !r[m_owner]
           || (m_shown >= HOLD && (r & ~(3'(1 << m_owner))) != 3'b000)
           || (r[0] && m_owner != 0);
      if (leave) begin
        m_mode = 2; m_gapleft = GAP; m_owner = -1; m_seg = 0;
      end else begin
        m_shown++;
        if (blink[m_owner]) begin
          m_blinkage++;
          m_seg = ((m_blinkage / BLINK) % 2) == 0;
        end else begin
          m_blinkage = 0;
          m_seg = 1;
        end
      end
    end else if (m_mode == 2 && m_gapleft > 1) begin
      m_gapleft--;
    end else if (r != 3'b000) begin
      if (r[0]) idx = 0;
      else begin
        idx = ((m_last - 1 + 1) % 2) + 1;
        if (!r[idx]) idx = ((m_last - 1 + 2) % 2) + 1;
      end
      m_owner = idx; m_last = idx; m_mode = 1; m_shown = 1;
      m_blinkage = 0; m_seg = 1;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] b);
    req   = r;
    blink = b;
  endtask

  task automatic do_reset();
    sys_rst = 1;
    applyStimulus(3'b000, 3'b000);
    tick();
    tick();
    sys_rst = 0;
  endtask

  task automatic test_reset();
    sys_rst = 1;
    applyStimulus(3'b111, 3'b000);
    tick();
    tick();
    checks++;
    if (obs_vec() !== 27'd0) $display("[TB] FAIL reset_outputs got=%h exp=0", obs_vec());
    else passes++;
    checks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
    else passes++;
    sys_rst = 0;
    tick();
    checks++;
    if (grant !== 3'b001) $display("[TB] FAIL reset_release_grant got=%b exp=001", grant);
    else passes++;
    checks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL reset_release_model got=%h exp=%h", obs_vec(), exp_vec());
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [2:0] eg;
    do_reset();
    data1 = 16'h0012;
    data2 = 16'h0034;
    applyStimulus(3'b110, 3'b000);
    for (int c = 1; c <= 21; c++) begin
      tick();
      eg = (c <= 8) ? 3'b010 : (c <= 10) ? 3'b000 : (c <= 18) ? 3'b100 :
           (c <= 20) ? 3'b000 : 3'b010;
      checks++;
      if (grant !== eg) $display("[TB] FAIL rr_grant cyc=%0d got=%b exp=%b", c, grant, eg);
      else passes++;
      checks++;
      if (obs_vec() !== exp_vec())
        $display("[TB] FAIL rr_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else passes++;
    end
    checks++;
    if (disp_data !== 16'h0034) $display("[TB] FAIL rr_data_hold got=%h exp=0034", disp_data);
    else passes++;
  endtask

  task automatic test_preempt();
    logic [2:0] eg;
    do_reset();
    applyStimulus(3'b010, 3'b000);
    tick();
    tick();
    tick();
    applyStimulus(3'b011, 3'b000);
    for (int c = 1; c <= 3; c++) begin
      tick();
      eg = (c <= 2) ? 3'b000 : 3'b001;
      checks++;
      if ({grant, disp_seg_en} !== {eg, c == 3})
        $display("[TB] FAIL preempt cyc=%0d got=%b/%b exp=%b/%b", c, grant, disp_seg_en, eg, c == 3);
      else passes++;
      checks++;
      if (obs_vec() !== exp_vec())
        $display("[TB] FAIL preempt_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else passes++;
    end
  endtask

  task automatic test_sole_requester();
    do_reset();
    applyStimulus(3'b010, 3'b000);
    for (int c = 1; c <= 14; c++) begin
      tick();
      checks++;
      if ({grant, disp_seg_en} !== 4'b0101)
        $display("[TB] FAIL sole_hold cyc=%0d got=%b/%b exp=010/1", c, grant, disp_seg_en);
      else passes++;
    end
    applyStimulus(3'b000, 3'b000);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if ({grant, disp_seg_en} !== 4'b0000 || obs_vec() !== exp_vec())
        $display("[TB] FAIL sole_release cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else passes++;
    end
  endtask

  task automatic test_blink();
    logic es;
    do_reset();
    applyStimulus(3'b100, 3'b100);
    for (int i = 0; i < 16; i++) begin
      tick();
      es = ((i / 4) % 2) == 0;
      checks++;
      if (disp_seg_en !== es || grant !== 3'b100)
        $display("[TB] FAIL blink_pattern i=%0d got=%b exp=%b", i, disp_seg_en, es);
      else passes++;
    end
    applyStimulus(3'b100, 3'b000);
    tick();
    checks++;
    if (disp_seg_en !== 1'b1) $display("[TB] FAIL blink_clear got=%b exp=1", disp_seg_en);
    else passes++;
    checks++;
    if (obs_vec() !== exp_vec()) $display("[TB] FAIL blink_model got=%h exp=%h", obs_vec(), exp_vec());
    else passes++;
  endtask

  task automatic test_gap_reset();
    do_reset();
    data1 = 16'h0012;
    applyStimulus(3'b010, 3'b000);
    tick();
    tick();
    tick();
    applyStimulus(3'b000, 3'b000);
    tick();
    checks++;
    if ({grant, disp_seg_en} !== 4'b0000 || disp_data !== 16'h0012)
      $display("[TB] FAIL gap_entry got=%b/%b/%h exp=000/0/0012", grant, disp_seg_en, disp_data);
    else passes++;
    sys_rst = 1;
    tick();
    checks++;
    if (obs_vec() !== 27'd0) $display("[TB] FAIL gap_reset got=%h exp=0", obs_vec());
    else passes++;
    sys_rst = 0;
    applyStimulus(3'b110, 3'b000);
    tick();
    checks++;
    if (grant !== 3'b010) $display("[TB] FAIL gap_reset_ptr got=%b exp=010", grant);
    else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
        if ($urandom_range(0, 29) == 0) blink[b] = ~blink[b];
      end
      data0  = 16'($urandom);
      data1  = 16'($urandom);
      data2  = 16'($urandom);
      point0 = 6'($urandom);
      point1 = 6'($urandom);
      point2 = 6'($urandom);
      sign   = 3'($urandom);
      sys_rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec())
        $display("[TB] FAIL random_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      else passes++;
      if (c % 50 == 0) begin
        checks++;
        if (!$onehot0(grant)) $display("[TB] FAIL random_onehot cyc=%0d got=%b exp=onehot0", c, grant);
        else passes++;
      end
    end
    sys_rst = 0;
  endtask

  initial begin
    sys_clk = 0;
    sys_rst = 1;
    req = 0; blink = 0; sign = 0;
    data0 = 0; data1 = 0; data2 = 0;
    point0 = 0; point1 = 0; point2 = 0;
    m_mode = 0; m_owner = -1; m_last = 2; m_shown = 0; m_gapleft = 0;
    m_blinkage = 0; m_seg = 0; m_sign = 0; m_point = 0; m_data = 0;
    @(negedge sys_clk);
    test_reset();
    test_round_robin();
    test_preempt();
    test_sole_requester();
    test_blink();
    test_gap_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
